// File: rtl/global_sram_rd_streamer.sv
// rtl/global_sram_rd_streamer.sv - burst reader for global_sram streaming words out through a credit-checked FIFO
module global_sram_rd_streamer #(
  parameter int DATA_BIT   = 32,
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [AW-1:0]       i_cmd_addr,
  input  logic [AW-1:0]       i_cmd_len,
  output logic [AW-1:0]       o_sram_addr,
  output logic                o_sram_ren,
  input  logic [DATA_BIT-1:0] i_sram_rdata,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DATA_BIT-1:0] o_out_data,
  output logic                o_out_last,
  output logic                o_busy,
  output logic                o_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_next_addr;
  logic [AW-1:0]       r_last_addr;
  logic [AW-1:0]       r_remaining;
  logic                r_inflight;
  logic                r_inflight_last;
  logic [DATA_BIT-1:0] r_mem_data [FIFO_DEPTH];
  logic                r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_done;

  logic                w_accept;
  logic                w_ren;
  logic                w_last_ren;
  logic                w_push;
  logic                w_pop;
  logic                w_last_pop;
  logic [CW:0]         w_occ;

  assign w_accept   = (r_state == S_IDLE) && i_cmd_valid;
  // A read already in flight has claimed a FIFO slot, so it counts against the credit.
  assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_ren      = (r_state == S_READ) && (r_remaining != '0) && (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_last_ren = w_ren && (r_remaining == AW'(1));
  assign w_push     = r_inflight;
  assign w_pop      = (r_count != '0) && i_out_ready;
  assign w_last_pop = w_pop && r_mem_last[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (i_cmd_len != '0)) w_state_nxt = S_READ;
      S_READ:  if (w_last_ren) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_pop && !r_inflight && (r_count == CW'(1))) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_next_addr     <= '0;
      r_last_addr     <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_ren;
      r_inflight_last <= w_last_ren;
      r_done          <= (w_accept && (i_cmd_len == '0)) ||
                         ((r_state == S_DRAIN) && (w_state_nxt == S_IDLE));
      if (w_accept) begin
        r_next_addr <= i_cmd_addr;
        r_remaining <= i_cmd_len;
      end else if (w_ren) begin
        r_last_addr <= r_next_addr;
        r_next_addr <= (r_next_addr == AW'(DEPTH - 1)) ? '0 : r_next_addr + AW'(1);
        r_remaining <= r_remaining - AW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_sram_rdata;
      r_mem_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  // The address shown during a read is the one being fetched; otherwise it holds the last fetched one.
  assign o_sram_addr = w_ren ? r_next_addr : r_last_addr;
  assign o_sram_ren  = w_ren;
  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_out_valid = (r_count != '0);
  assign o_out_data  = o_out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign o_out_last  = o_out_valid && r_mem_last[r_rd_ptr];
endmodule

// File: tb/tb_global_sram_rd_streamer.sv
// tb/tb_global_sram_rd_streamer.sv - self-checking bench for global_sram_rd_streamer
module tb_global_sram_rd_streamer;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int FD    = 4;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [AW-1:0] sram_addr;
  logic          sram_ren;
  logic [DW-1:0] sram_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  global_sram_rd_streamer #(.DATA_BIT(DW), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .o_sram_addr(sram_addr), .o_sram_ren(sram_ren), .i_sram_rdata(sram_rdata),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data), .o_out_last(out_last),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = {{(DW-AW){1'b0}}, a};
    return (t * 16'h0123) ^ 16'hBEEF;
  endfunction

  always @(posedge clk) if (sram_ren) sram_rdata <= word_of(sram_addr);

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  int            n_ren = 0, n_xfer = 0, n_last = 0, n_done = 0, n_valid = 0;
  int            last_xfer_cyc = 0, done_cyc = 0, first_ren_cyc = 0, first_valid_cyc = 0;
  logic [AW-1:0] last_ren_addr = '0;
  logic          done_busy = 1'b0;
  logic          arm_ren = 1'b0, arm_valid = 1'b0;
  logic          hold = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
        check("hold_last", out_last, hold_l);
      end
      if (sram_ren) begin
        n_ren++;
        last_ren_addr = sram_addr;
        if (arm_ren) begin first_ren_cyc = cyc; arm_ren = 1'b0; end
        check("ren_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("ren_addr", sram_addr, addr_q.pop_front());
      end
      if (out_valid) begin
        n_valid++;
        if (arm_valid) begin first_valid_cyc = cyc; arm_valid = 1'b0; end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        n_xfer++;
        last_xfer_cyc = cyc;
        if (out_last) n_last++;
        check("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
      end
      if (done) begin
        n_done++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] len, input bit rnd, output int acc);
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] x;
      x = AW'((int'(a) + i) % DEPTH);
      addr_q.push_back(x);
      exp_q.push_back('{word_of(x), (i == int'(len) - 1)});
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
    acc = -1;
    for (int k = 0; k < 500 && acc < 0; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cmd_ready) acc = cyc;
      step();
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", acc >= 0, 1);
  endtask

  task automatic wait_done(input int target, input bit rnd);
    for (int k = 0; k < 3000 && n_done < target; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("done_reached", n_done >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_ren"}, sram_ren, 0);
    check({tag, "_sram_addr"}, sram_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    int            reads;
    logic [AW-1:0] end_addr;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int acc, r0, d0, v0, l0, x0;
    vecs[0] = '{7'h10, 7'd4, 4, 7'h13};
    vecs[1] = '{7'd62, 7'd4, 4, 7'd1};
    vecs[2] = '{7'd0, 7'd1, 1, 7'd0};
    vecs[3] = '{7'd5, 7'd7, 7, 7'd11};
    vecs[4] = '{7'd60, 7'd70, 70, 7'd1};

    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check_reset_outputs("rst0");
    step();
    rst = 1'b0;

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      r0 = n_ren; d0 = n_done;
      arm_ren = 1'b1; arm_valid = 1'b1;
      issue(vecs[i].addr, vecs[i].len, 1'b0, acc);
      wait_done(d0 + 1, 1'b0);
      check("ren_count", n_ren - r0, vecs[i].reads);
      check("end_addr", last_ren_addr, vecs[i].end_addr);
      check("first_ren_lat", first_ren_cyc, acc + 1);
      check("first_valid_lat", first_valid_cyc, acc + 3);
      check("done_after_last", done_cyc, last_xfer_cyc + 1);
      check("busy_at_done", done_busy, 0);
      check("exp_q_empty", exp_q.size(), 0);
      check("addr_q_empty", addr_q.size(), 0);
    end

    out_ready = 1'b0;
    r0 = n_ren; d0 = n_done; l0 = n_last; x0 = n_xfer;
    issue(7'h20, 7'd8, 1'b0, acc);
    repeat (10) step();
    check("bp_ren_count", n_ren - r0, FD);
    check("bp_valid", out_valid, 1);
    check("bp_no_xfer", n_xfer - x0, 0);
    out_ready = 1'b1;
    wait_done(d0 + 1, 1'b0);
    check("bp_all_words", n_xfer - x0, 8);
    check("bp_last_count", n_last - l0, 1);
    check("bp_exp_q_empty", exp_q.size(), 0);

    r0 = n_ren; d0 = n_done; v0 = n_valid;
    issue(7'd5, 7'd0, 1'b0, acc);
    check("len0_done", done, 1);
    check("len0_cmd_ready", cmd_ready, 1);
    check("len0_busy", busy, 0);
    repeat (3) step();
    check("len0_done_once", n_done - d0, 1);
    check("len0_no_ren", n_ren - r0, 0);
    check("len0_no_valid", n_valid - v0, 0);

    out_ready = 1'b0;
    issue(7'h30, 7'd8, 1'b0, acc);
    repeat (3) step();
    check("mid_valid", out_valid, 1);
    check("mid_ren", sram_ren, 1);
    rst = 1'b1;
    step();
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_reset_outputs("rst1");
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    d0 = n_done; x0 = n_xfer;
    issue(7'h08, 7'd5, 1'b0, acc);
    wait_done(d0 + 1, 1'b0);
    check("post_rst_words", n_xfer - x0, 5);
    check("post_rst_exp_q_empty", exp_q.size(), 0);

    d0 = n_done; l0 = n_last; x0 = n_xfer;
    issue(7'd40, 7'd6, 1'b1, acc);
    issue(7'd63, 7'd1, 1'b1, acc);
    issue(7'd58, 7'd9, 1'b1, acc);
    wait_done(d0 + 3, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    check("rnd_words", n_xfer - x0, 16);
    check("rnd_last_count", n_last - l0, 3);
    check("rnd_done_count", n_done - d0, 3);
    check("rnd_exp_q_empty", exp_q.size(), 0);
    check("rnd_addr_q_empty", addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
